// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions, PC stage state encoding.
// Pure declarations; no timing or backpressure of its own.
package cpu_pkg;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GTE = 3'b100;
  localparam logic [2:0] COND_LTE = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef logic [2:0] flags_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // imm9 is a signed word offset; scale to bytes and widen to PC width.
  function automatic logic [15:0] b_offset(input logic [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/pc_control_if.sv
// Decode-to-PC-stage bus: branch/halt/flag controls in, PC, flags and status out.
// Combinational wiring only; stall is the sole hold mechanism.
interface pc_control_if;
  import cpu_pkg::*;

  logic        stall;
  logic        halt;
  logic        br_valid;
  logic        br_reg;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] rs_data;
  flags_t      flag_wen;
  flags_t      flag_in;
  logic [15:0] pc;
  flags_t      flags;
  logic        taken;
  logic        halted;

  modport master (
    output stall, halt, br_valid, br_reg, cond, imm9, rs_data, flag_wen, flag_in,
    input  pc, flags, taken, halted
  );

  modport slave (
    input  stall, halt, br_valid, br_reg, cond, imm9, rs_data, flag_wen, flag_in,
    output pc, flags, taken, halted
  );

endinterface

// File: rtl/branch_cond.sv
// Evaluates a 3-bit branch condition against the registered {N,V,Z} flags.
// Purely combinational, zero latency, no backpressure.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  flags_t     flags,
  output logic       cond_true
);

  logic n, v, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NE:  cond_true = !z;
      COND_EQ:  cond_true = z;
      COND_GT:  cond_true = !z && !n;
      COND_LT:  cond_true = n;
      COND_GTE: cond_true = z || !n;
      COND_LTE: cond_true = n || z;
      COND_OV:  cond_true = v;
      COND_UNC: cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// PC and N/Z/V flag register ahead of fetch; evaluates B/BR and implements HLT.
// pc/flags/halted update one edge after inputs, taken is same-cycle; stall holds PC and flags.
module pc_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         rst_n,
  pc_control_if.slave bus
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  flags_t      flags_q, flags_d;
  logic [15:0] pc_inc_2;
  logic [15:0] br_target;
  logic        cond_true;
  logic        commit;
  logic        taken;

  branch_cond u_branch_cond (
    .cond      (bus.cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign pc_inc_2  = pc_q + 16'd2;
  // BR targets are used verbatim, odd addresses included.
  assign br_target = bus.br_reg ? bus.rs_data : (pc_inc_2 + b_offset(bus.imm9));
  assign commit    = (state_q == ST_RUN) && !bus.stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state: only reset leaves HALTED
  always_comb begin
    state_d = state_q;
    if (commit && bus.halt) state_d = ST_HALTED;
  end

  // Outputs and datapath next values
  always_comb begin
    taken   = bus.br_valid && cond_true && commit && !bus.halt;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (commit) begin
      // Branch above already sampled flags_q, so same-cycle writes land afterwards.
      flags_d = (flags_q & ~bus.flag_wen) | (bus.flag_in & bus.flag_wen);
      if (bus.halt)  pc_d = pc_q;
      else if (taken) pc_d = br_target;
      else           pc_d = pc_inc_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.flags  = flags_q;
  assign bus.taken  = taken;
  assign bus.halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_control.sv
// Randomised and directed bench for pc_control against an abstract PC/flags model.
module tb_pc_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model state
  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  logic        m_halted;

  pc_control_if bus ();

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return z == 1'b0;
      3'd1: return z == 1'b1;
      3'd2: return (z == 1'b0) && (n == 1'b0);
      3'd3: return n == 1'b1;
      3'd4: return (z == 1'b1) || (n == 1'b0);
      3'd5: return (n == 1'b1) || (z == 1'b1);
      3'd6: return v == 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_taken();
    return bus.br_valid && !m_halted && !bus.stall && !bus.halt
           && cond_holds(bus.cond, m_flags);
  endfunction

  function automatic logic [15:0] exp_target();
    int off, v;
    if (bus.br_reg) return bus.rs_data;
    off = int'($signed(bus.imm9));
    v = int'(m_pc) + 2 + 2 * off;
    v = (v + 65536 * 2) % 65536;
    return 16'(v);
  endfunction

  // Advance the model by one committed edge using the inputs currently driven.
  task automatic model_step();
    logic        tk;
    logic [15:0] tgt;
    tk  = exp_taken();
    tgt = exp_target();
    if (!m_halted && !bus.stall) begin
      for (int i = 0; i < 3; i++)
        if (bus.flag_wen[i]) m_flags[i] = bus.flag_in[i];
      if (bus.halt)   m_halted = 1'b1;
      else if (tk)    m_pc = tgt;
      else            m_pc = 16'((int'(m_pc) + 2) % 65536);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.halt = 0; bus.br_valid = 0; bus.br_reg = 0;
    bus.cond = 3'd0; bus.imm9 = 9'd0; bus.rs_data = 16'd0;
    bus.flag_wen = 3'b000; bus.flag_in = 3'b000;
  endtask

  task automatic jump_to(input logic [15:0] addr);
    idle_inputs();
    bus.br_valid = 1; bus.br_reg = 1; bus.cond = 3'd7; bus.rs_data = addr;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_pc = 16'h0000; m_flags = 3'b000; m_halted = 1'b0;
    #1;
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", bus.pc); end
    checks++; if (bus.flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", bus.flags); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.pc !== 16'(2 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, 16'(2 * i)); end
      checks++; if (bus.flags !== 3'b000 || bus.halted !== 1'b0) begin errors++; $display("FAIL seq_status[%0d]: got flags %b halted %b expected 000/0", i, bus.flags, bus.halted); end
    end
  endtask

  task automatic test_branch_b();
    idle_inputs();
    bus.flag_wen = 3'b001; bus.flag_in = 3'b001;
    tick();
    jump_to(16'h0010);
    bus.br_valid = 1; bus.cond = 3'd1; bus.imm9 = 9'h1FE;
    #1;
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL b_eq_taken: got %b expected 1", bus.taken); end
    tick();
    checks++; if (bus.pc !== 16'h000E || bus.pc !== m_pc) begin errors++; $display("FAIL b_eq_pc: got %h expected 000e", bus.pc); end
    jump_to(16'h0010);
    bus.br_valid = 1; bus.cond = 3'd0; bus.imm9 = 9'h1FE;
    #1;
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL b_ne_taken: got %b expected 0", bus.taken); end
    tick();
    checks++; if (bus.pc !== 16'h0012 || bus.pc !== m_pc) begin errors++; $display("FAIL b_ne_pc: got %h expected 0012", bus.pc); end
  endtask

  task automatic test_wrap_br();
    jump_to(16'hFFFE);
    bus.br_valid = 1; bus.cond = 3'd7; bus.imm9 = 9'd0;
    tick();
    checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", bus.pc); end
    jump_to(16'h1234);
    checks++; if (bus.pc !== 16'h1234) begin errors++; $display("FAIL br_pc: got %h expected 1234", bus.pc); end
    jump_to(16'h1235);
    checks++; if (bus.pc !== 16'h1235) begin errors++; $display("FAIL br_odd_pc: got %h expected 1235", bus.pc); end
  endtask

  task automatic test_flag_overlap();
    idle_inputs();
    bus.flag_wen = 3'b111; bus.flag_in = 3'b000;
    tick();
    idle_inputs();
    bus.flag_wen = 3'b001; bus.flag_in = 3'b001; bus.br_valid = 1; bus.cond = 3'd1; bus.imm9 = 9'h010;
    #1;
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL overlap_old_flags: got %b expected 0", bus.taken); end
    tick();
    idle_inputs();
    bus.br_valid = 1; bus.cond = 3'd1; bus.imm9 = 9'h010;
    #1;
    checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL overlap_new_flags: got %b expected 1", bus.taken); end
    tick();
    checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL overlap_pc: got %h expected %h", bus.pc, m_pc); end
    idle_inputs();
    bus.stall = 1; bus.flag_wen = 3'b111; bus.flag_in = 3'b110; bus.br_valid = 1; bus.cond = 3'd7;
    #1;
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL stall_taken: got %b expected 0", bus.taken); end
    tick();
    checks++; if (bus.flags !== 3'b001 || bus.pc !== m_pc) begin errors++; $display("FAIL stall_hold: got flags %b pc %h expected 001 %h", bus.flags, bus.pc, m_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.halt     = 1'b0;
      bus.br_valid = $urandom_range(0, 1);
      bus.br_reg   = $urandom_range(0, 1);
      bus.cond     = 3'($urandom);
      bus.imm9     = 9'($urandom);
      bus.rs_data  = 16'($urandom);
      bus.flag_wen = 3'($urandom);
      bus.flag_in  = 3'($urandom);
      #1;
      checks++; if (bus.taken !== exp_taken()) begin errors++; $display("FAIL rand_taken[%0d]: got %b expected %b", i, bus.taken, exp_taken()); end
      tick();
      checks++; if (bus.pc !== m_pc || bus.flags !== m_flags || bus.halted !== m_halted) begin
        errors++;
        $display("FAIL rand_state[%0d]: got pc %h flags %b halted %b expected %h %b %b", i, bus.pc, bus.flags, bus.halted, m_pc, m_flags, m_halted);
      end
    end
  endtask

  task automatic test_halt();
    jump_to(16'h0020);
    bus.halt = 1; bus.stall = 1;
    tick();
    checks++; if (bus.halted !== 1'b0 || bus.pc !== 16'h0020) begin errors++; $display("FAIL halt_stalled: got halted %b pc %h expected 0 0020", bus.halted, bus.pc); end
    idle_inputs();
    bus.halt = 1; bus.br_valid = 1; bus.cond = 3'd7; bus.flag_wen = 3'b100; bus.flag_in = 3'b100;
    #1;
    checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL halt_taken: got %b expected 0", bus.taken); end
    tick();
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 16'h0020 || bus.flags !== m_flags) begin
      errors++; $display("FAIL halt_enter: got halted %b pc %h flags %b expected 1 0020 %b", bus.halted, bus.pc, bus.flags, m_flags);
    end
    for (int i = 0; i < 10; i++) begin
      bus.stall = $urandom_range(0, 1); bus.halt = $urandom_range(0, 1);
      bus.br_valid = 1; bus.br_reg = $urandom_range(0, 1); bus.cond = 3'd7;
      bus.rs_data = 16'($urandom); bus.imm9 = 9'($urandom);
      bus.flag_wen = 3'b111; bus.flag_in = 3'($urandom);
      #1;
      checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL halted_taken[%0d]: got %b expected 0", i, bus.taken); end
      tick();
      checks++; if (bus.pc !== 16'h0020 || bus.halted !== 1'b1 || bus.flags !== m_flags) begin
        errors++; $display("FAIL halted_hold[%0d]: got pc %h halted %b flags %b expected 0020 1 %b", i, bus.pc, bus.halted, bus.flags, m_flags);
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 16'h0000 || bus.flags !== 3'b000 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc %h flags %b halted %b expected 0000 000 0", bus.pc, bus.flags, bus.halted);
    end
    idle_inputs();
    m_pc = 16'h0000; m_flags = 3'b000; m_halted = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.pc !== 16'h0002 || bus.halted !== 1'b0) begin errors++; $display("FAIL post_reset_run: got pc %h halted %b expected 0002 0", bus.pc, bus.halted); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_branch_b();
    test_wrap_br();
    test_flag_overlap();
    test_random();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
